// File: rtl/div_pkg.sv
// Shared constants for the programmable clock divider: default widths,
// reset divisor, system clock rate and channel index width.
package div_pkg;
  localparam int          CNT_W_DEF       = 27;
  localparam int unsigned DEFAULT_DIV_DEF = 100_000_000;
  localparam int unsigned CLK_HZ          = 100_000_000;
  localparam int          CH_IDX_W        = 3;
endpackage

// File: rtl/divider_channel.sv
// One divider channel: active/shadow divisor, phase counter, registered
// tick/clk_out/pending outputs.
module divider_channel #(
  parameter int          CNT_W       = div_pkg::CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = div_pkg::DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             ld_imm,
  input  logic             ld_def,
  input  logic [CNT_W-1:0] ld_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d, n_eff;
  logic             clk_out_q, clk_out_d, tick_q, tick_d, pend_q, pend_d;
  logic             wrap;

  // A zero divisor behaves as divide-by-one so the compare never underflows.
  assign n_eff = (act_q == '0) ? CNT_W'(1) : act_q;
  assign wrap  = en && (cnt_q == n_eff - CNT_W'(1));

  always_comb begin
    cnt_d     = cnt_q;
    act_d     = act_q;
    shd_d     = shd_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    pend_d    = pend_q;
    if (ld_imm) begin
      act_d     = ld_div;
      cnt_d     = '0;
      clk_out_d = 1'b0;
      pend_d    = 1'b0;
    end else begin
      if (wrap) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
        if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end else if (en) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // A deferred write on the wrap edge lands in the shadow only and
      // re-arms pending for the following wrap.
      if (ld_def) begin
        shd_d  = ld_div;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      act_q     <= RST_DIV;
      shd_q     <= RST_DIV;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pend_q;
endmodule

// File: rtl/programmable_divider.sv
// Multi-channel programmable divider: decodes the load strobe and fans it
// out to NUM_CH independent divider_channel instances.
module programmable_divider
  import div_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                load,
  input  logic [CH_IDX_W-1:0] load_ch,
  input  logic [CNT_W-1:0]    load_div,
  input  logic                load_now,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   pending
);
  // Indices >= NUM_CH match no instance, so out-of-range loads are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = load && (load_ch == CH_IDX_W'(i));

    divider_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (ch_en[i]),
      .ld_imm  (sel && load_now),
      .ld_def  (sel && !load_now),
      .ld_div  (load_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pending (pending[i])
    );
  end
endmodule

// File: tb/tb_programmable_divider.sv
// Directed bench for programmable_divider with CNT_W=8, DEFAULT_DIV=4, NUM_CH=2.
module tb_programmable_divider;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              load;
  logic [2:0]        load_ch;
  logic [CNT_W-1:0]  load_div;
  logic              load_now;
  logic [NUM_CH-1:0] clk_out, tick, pending;

  int n_vec = 0;
  int n_err = 0;

  programmable_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .load(load), .load_ch(load_ch),
    .load_div(load_div), .load_now(load_now), .clk_out(clk_out), .tick(tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; load_now = 1'b0; ch_en = 2'b11;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_en = 2'b11; load = 1'b1; load_ch = 3'd0; load_div = 8'd9; load_now = 1'b1;
    step(); step();
    load = 1'b0; load_now = 1'b0;
    n_vec++; if (tick !== 2'b00) begin n_err++; $display("FAIL reset_tick got %b exp 00", tick); end
    n_vec++; if (clk_out !== 2'b00) begin n_err++; $display("FAIL reset_clk_out got %b exp 00", clk_out); end
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL reset_pending got %b exp 00", pending); end
    reset = 1'b0;
  endtask

  task automatic test_default_period();
    logic t; logic c;
    for (int e = 1; e <= 12; e++) begin
      step();
      t = (e % 4 == 0); c = ((e / 4) % 2) == 1;
      n_vec++; if (tick !== {t, t}) begin n_err++; $display("FAIL dflt_tick e=%0d got %b exp %b", e, tick, {t, t}); end
      n_vec++; if (clk_out !== {c, c}) begin n_err++; $display("FAIL dflt_clk e=%0d got %b exp %b", e, clk_out, {c, c}); end
    end
  endtask

  task automatic test_deferred();
    logic t0, c0, t1, c1;
    do_reset();
    step();
    load = 1'b1; load_ch = 3'd0; load_div = 8'd6; load_now = 1'b0;
    step();
    load = 1'b0;
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL defer_pend_e2 got %b exp 01", pending); end
    step();
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL defer_pend_e3 got %b exp 01", pending); end
    step();
    n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL defer_pend_e4 got %b exp 00", pending); end
    n_vec++; if (tick !== 2'b11) begin n_err++; $display("FAIL defer_tick_e4 got %b exp 11", tick); end
    for (int e = 5; e <= 16; e++) begin
      step();
      t0 = (e == 10 || e == 16); c0 = (e < 10) || (e >= 16);
      t1 = (e % 4 == 0);         c1 = ((e / 4) % 2) == 1;
      n_vec++; if (tick !== {t1, t0}) begin n_err++; $display("FAIL defer_tick e=%0d got %b exp %b", e, tick, {t1, t0}); end
      n_vec++; if (clk_out !== {c1, c0}) begin n_err++; $display("FAIL defer_clk e=%0d got %b exp %b", e, clk_out, {c1, c0}); end
    end
  endtask

  task automatic test_immediate();
    logic t0, c0, t1, c1;
    do_reset();
    repeat (4) step();
    load = 1'b1; load_ch = 3'd1; load_div = 8'd3; load_now = 1'b1;
    step();
    load = 1'b0; load_now = 1'b0;
    n_vec++; if (clk_out !== 2'b01) begin n_err++; $display("FAIL imm_clk_e5 got %b exp 01", clk_out); end
    n_vec++; if (tick !== 2'b00) begin n_err++; $display("FAIL imm_tick_e5 got %b exp 00", tick); end
    for (int e = 6; e <= 11; e++) begin
      step();
      t0 = (e == 8);             c0 = (e < 8);
      t1 = (e == 8 || e == 11);  c1 = (e >= 8 && e < 11);
      n_vec++; if (tick !== {t1, t0}) begin n_err++; $display("FAIL imm_tick e=%0d got %b exp %b", e, tick, {t1, t0}); end
      n_vec++; if (clk_out !== {c1, c0}) begin n_err++; $display("FAIL imm_clk e=%0d got %b exp %b", e, clk_out, {c1, c0}); end
    end
  endtask

  task automatic test_wrap_zero_badch();
    logic t0, c0, t1, c1; logic [1:0] p;
    do_reset();
    repeat (3) step();
    load = 1'b1; load_ch = 3'd0; load_div = 8'd0; load_now = 1'b0;
    step();
    load = 1'b0;
    n_vec++; if (tick !== 2'b11) begin n_err++; $display("FAIL wrapld_tick_e4 got %b exp 11", tick); end
    n_vec++; if (pending !== 2'b01) begin n_err++; $display("FAIL wrapld_pend_e4 got %b exp 01", pending); end
    for (int e = 5; e <= 18; e++) begin
      if (e == 15) begin load = 1'b1; load_ch = 3'd5; load_div = 8'd2; load_now = 1'b1; end
      if (e == 16) begin load = 1'b1; load_ch = 3'd5; load_div = 8'd2; load_now = 1'b0; end
      step();
      load = 1'b0; load_now = 1'b0;
      t0 = (e >= 8);     c0 = (e < 8) ? 1'b1 : (e % 2 == 1);
      t1 = (e % 4 == 0); c1 = ((e / 4) % 2) == 1;
      p  = (e < 8) ? 2'b01 : 2'b00;
      n_vec++; if (tick !== {t1, t0}) begin n_err++; $display("FAIL zero_tick e=%0d got %b exp %b", e, tick, {t1, t0}); end
      n_vec++; if (clk_out !== {c1, c0}) begin n_err++; $display("FAIL zero_clk e=%0d got %b exp %b", e, clk_out, {c1, c0}); end
      n_vec++; if (pending !== p) begin n_err++; $display("FAIL zero_pend e=%0d got %b exp %b", e, pending, p); end
    end
  endtask

  task automatic test_disable();
    logic t0, c0, t1, c1;
    do_reset();
    repeat (5) step();
    ch_en = 2'b10;
    for (int e = 6; e <= 10; e++) begin
      step();
      t1 = (e % 4 == 0); c1 = ((e / 4) % 2) == 1;
      n_vec++; if (tick !== {t1, 1'b0}) begin n_err++; $display("FAIL dis_tick e=%0d got %b exp %b", e, tick, {t1, 1'b0}); end
      n_vec++; if (clk_out !== {c1, 1'b1}) begin n_err++; $display("FAIL dis_clk e=%0d got %b exp %b", e, clk_out, {c1, 1'b1}); end
    end
    ch_en = 2'b11;
    for (int e = 11; e <= 17; e++) begin
      step();
      t0 = (e == 13 || e == 17); c0 = (e < 13) || (e >= 17);
      t1 = (e % 4 == 0);         c1 = ((e / 4) % 2) == 1;
      n_vec++; if (tick !== {t1, t0}) begin n_err++; $display("FAIL res_tick e=%0d got %b exp %b", e, tick, {t1, t0}); end
      n_vec++; if (clk_out !== {c1, c0}) begin n_err++; $display("FAIL res_clk e=%0d got %b exp %b", e, clk_out, {c1, c0}); end
    end
  endtask

  task automatic test_reset_pending();
    logic t, c;
    do_reset();
    repeat (4) step();
    load = 1'b1; load_ch = 3'd1; load_div = 8'd7; load_now = 1'b0;
    step();
    load = 1'b0;
    n_vec++; if (pending !== 2'b10) begin n_err++; $display("FAIL rp_pend_pre got %b exp 10", pending); end
    n_vec++; if (clk_out !== 2'b11) begin n_err++; $display("FAIL rp_clk_pre got %b exp 11", clk_out); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if ({tick, clk_out, pending} !== 6'b0) begin n_err++; $display("FAIL rp_outs got %b exp 000000", {tick, clk_out, pending}); end
    for (int e = 1; e <= 8; e++) begin
      step();
      t = (e % 4 == 0); c = ((e / 4) % 2) == 1;
      n_vec++; if (tick !== {t, t}) begin n_err++; $display("FAIL rp_tick e=%0d got %b exp %b", e, tick, {t, t}); end
      n_vec++; if (clk_out !== {c, c}) begin n_err++; $display("FAIL rp_clk e=%0d got %b exp %b", e, clk_out, {c, c}); end
      n_vec++; if (pending !== 2'b00) begin n_err++; $display("FAIL rp_pend e=%0d got %b exp 00", e, pending); end
    end
  endtask

  initial begin
    reset = 1'b1; ch_en = 2'b00; load = 1'b0; load_ch = 3'd0; load_div = '0; load_now = 1'b0;
    test_reset();
    test_default_period();
    test_deferred();
    test_immediate();
    test_wrap_zero_badch();
    test_disable();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
